// File: rtl/icb_arb_pkg.sv
// Shared types and constants for the two-master ICB round-robin arbiter.
// Latency: none, since this file holds only declarations. Backpressure: not applicable.
package icb_arb_pkg;

  typedef logic icb_id_t;

  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;

  localparam icb_id_t M_HOST = 1'b0;
  localparam icb_id_t M_CONV = 1'b1;

  function automatic icb_id_t other_master(input icb_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/icb_ost_fifo.sv
// In-order FIFO of master IDs, one entry per outstanding command, with occupancy count.
// Latency: head is valid the cycle after a push. Backpressure: the caller must not push when full or pop when empty.
module icb_ost_fifo
  import icb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         push_id,
  input  logic                         pop,
  output logic                         head,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign cnt   = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/icb_rr_arbiter.sv
// Round-robin arbiter sharing one ICB SRAM slave between host (m0) and conv engine (m1), with in-order response routing.
// Latency: zero-cycle cmd/rsp muxing. Backpressure: slave ready and outstanding-limit gate cmd_ready; the head master's rsp_ready gates s_icb_rsp_ready.
module icb_rr_arbiter
  import icb_arb_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int AW        = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_icb_cmd_valid,
  output logic              m0_icb_cmd_ready,
  input  logic [AW-1:0]     m0_icb_cmd_addr,
  input  logic              m0_icb_cmd_read,
  input  logic [ICB_DW-1:0] m0_icb_cmd_wdata,
  input  logic [ICB_MW-1:0] m0_icb_cmd_wmask,
  output logic              m0_icb_rsp_valid,
  input  logic              m0_icb_rsp_ready,
  output logic [ICB_DW-1:0] m0_icb_rsp_rdata,

  input  logic              m1_icb_cmd_valid,
  output logic              m1_icb_cmd_ready,
  input  logic [AW-1:0]     m1_icb_cmd_addr,
  input  logic              m1_icb_cmd_read,
  input  logic [ICB_DW-1:0] m1_icb_cmd_wdata,
  input  logic [ICB_MW-1:0] m1_icb_cmd_wmask,
  output logic              m1_icb_rsp_valid,
  input  logic              m1_icb_rsp_ready,
  output logic [ICB_DW-1:0] m1_icb_rsp_rdata,

  output logic              s_icb_cmd_valid,
  input  logic              s_icb_cmd_ready,
  output logic [AW-1:0]     s_icb_cmd_addr,
  output logic              s_icb_cmd_read,
  output logic [ICB_DW-1:0] s_icb_cmd_wdata,
  output logic [ICB_MW-1:0] s_icb_cmd_wmask,
  input  logic              s_icb_rsp_valid,
  output logic              s_icb_rsp_ready,
  input  logic [ICB_DW-1:0] s_icb_rsp_rdata
);

  localparam int CW = $clog2(OST_DEPTH+1);

  logic    prio_q, prio_d;
  logic    lock_q, lock_d;
  icb_id_t lock_id_q, lock_id_d;

  icb_id_t gnt;
  logic    gnt_valid;
  logic    cmd_open;
  logic    cmd_acc;
  logic    rsp_acc;

  logic          fifo_head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;

  // While locked the stalled grant is held so the slave sees stable fields.
  always_comb begin
    gnt = prio_q;
    if (lock_q) begin
      gnt = lock_id_q;
    end else if (m0_icb_cmd_valid && !m1_icb_cmd_valid) begin
      gnt = M_HOST;
    end else if (m1_icb_cmd_valid && !m0_icb_cmd_valid) begin
      gnt = M_CONV;
    end
    gnt_valid = (gnt == M_CONV) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  end

  // No bypass: a pop in the same cycle does not open a full FIFO.
  assign cmd_open = !rst && !fifo_full;

  always_comb begin
    s_icb_cmd_valid = gnt_valid && cmd_open;
    s_icb_cmd_addr  = m0_icb_cmd_addr;
    s_icb_cmd_read  = m0_icb_cmd_read;
    s_icb_cmd_wdata = m0_icb_cmd_wdata;
    s_icb_cmd_wmask = m0_icb_cmd_wmask;
    if (gnt == M_CONV) begin
      s_icb_cmd_addr  = m1_icb_cmd_addr;
      s_icb_cmd_read  = m1_icb_cmd_read;
      s_icb_cmd_wdata = m1_icb_cmd_wdata;
      s_icb_cmd_wmask = m1_icb_cmd_wmask;
    end
  end

  assign m0_icb_cmd_ready = s_icb_cmd_ready && cmd_open && (gnt == M_HOST);
  assign m1_icb_cmd_ready = s_icb_cmd_ready && cmd_open && (gnt == M_CONV);
  assign cmd_acc          = s_icb_cmd_valid && s_icb_cmd_ready;

  assign m0_icb_rsp_valid = s_icb_rsp_valid && !fifo_empty && (fifo_head == M_HOST);
  assign m1_icb_rsp_valid = s_icb_rsp_valid && !fifo_empty && (fifo_head == M_CONV);
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign s_icb_rsp_ready  = !fifo_empty &&
                            ((fifo_head == M_CONV) ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign rsp_acc          = s_icb_rsp_valid && s_icb_rsp_ready;

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (cmd_acc) begin
      prio_d = other_master(gnt);
      lock_d = 1'b0;
    end else if (s_icb_cmd_valid) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= M_HOST;
      lock_q    <= 1'b0;
      lock_id_q <= M_HOST;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  icb_ost_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_ost_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_acc),
    .push_id (gnt),
    .pop     (rsp_acc),
    .head    (fifo_head),
    .cnt     (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  a_ost_bound : assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= CW'(OST_DEPTH));

endmodule

// File: tb/tb_icb_rr_arbiter.sv
// Directed bench for icb_rr_arbiter: reset, host read, fairness, lock, full, routing, reset mid-op.
module tb_icb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata, m0_icb_rsp_rdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata, m1_icb_rsp_rdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_rsp_rdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icb_rr_arbiter #(.OST_DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata)
  );

  task automatic idle();
    m0_icb_cmd_valid = 0; m0_icb_cmd_addr = 0; m0_icb_cmd_read = 0;
    m0_icb_cmd_wdata = 0; m0_icb_cmd_wmask = 4'hF; m0_icb_rsp_ready = 1;
    m1_icb_cmd_valid = 0; m1_icb_cmd_addr = 0; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = 0; m1_icb_cmd_wmask = 4'hF; m1_icb_rsp_ready = 1;
    s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
    s_icb_cmd_ready = 1; s_icb_rsp_valid = 1;
    step();
    checks++;
    if ({m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready,
         m0_icb_rsp_valid, m1_icb_rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {m0_icb_cmd_ready,
               m1_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
    end
    step();
    idle();
    rst = 0;
    #1;
    checks++;
    if ({s_icb_cmd_valid, s_icb_rsp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 00", {s_icb_cmd_valid, s_icb_rsp_ready});
    end
  endtask

  task automatic test_host_read();
    apply_reset();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h1004_0010; m0_icb_cmd_read = 1;
    s_icb_cmd_ready = 1;
    #1;
    checks++;
    if ({s_icb_cmd_valid, s_icb_cmd_read, m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_addr}
        !== {4'b1110, 32'h1004_0010}) begin
      errors++;
      $display("FAIL host_read_cmd: got %b addr %h expected 1110 addr 10040010",
               {s_icb_cmd_valid, s_icb_cmd_read, m0_icb_cmd_ready, m1_icb_cmd_ready}, s_icb_cmd_addr);
    end
    step();
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready, m0_icb_rsp_rdata}
        !== {3'b101, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL host_read_rsp: got %b rdata %h expected 101 rdata deadbeef",
               {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}, m0_icb_rsp_rdata);
    end
    step();
    s_icb_rsp_valid = 0;
    #1;
    checks++;
    if (s_icb_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL host_read_empty: got s_rsp_ready=%b expected 0", s_icb_rsp_ready);
    end
  endtask

  task automatic test_fairness();
    logic [33:0] exp;
    apply_reset();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h100;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200;
    s_icb_cmd_ready = 1; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = i[0] ? {2'b01, 32'h200} : {2'b10, 32'h100};
      checks++;
      if ({m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_addr} !== exp) begin
        errors++;
        $display("FAIL fairness_%0d: got rdy %b addr %h expected rdy %b addr %h", i,
                 {m0_icb_cmd_ready, m1_icb_cmd_ready}, s_icb_cmd_addr, exp[33:32], exp[31:0]);
      end
      step();
    end
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
    step();
    s_icb_rsp_valid = 0;
    #1;
    checks++;
    if (s_icb_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL fairness_drain: got s_rsp_ready=%b expected 0", s_icb_rsp_ready);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h1000; s_icb_cmd_ready = 1;
    step();
    m0_icb_cmd_addr = 32'h2000; s_icb_cmd_ready = 0;
    #1;
    checks++;
    if ({s_icb_cmd_valid, s_icb_cmd_addr} !== {1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL lock_stall0: got valid %b addr %h expected 1 addr 2000",
               s_icb_cmd_valid, s_icb_cmd_addr);
    end
    step();
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h3000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({s_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready} !== {32'h2000, 2'b00}) begin
        errors++;
        $display("FAIL lock_hold_%0d: got addr %h rdy %b expected addr 2000 rdy 00", i,
                 s_icb_cmd_addr, {m0_icb_cmd_ready, m1_icb_cmd_ready});
      end
      step();
    end
    s_icb_cmd_ready = 1;
    #1;
    checks++;
    if ({s_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready} !== {32'h2000, 2'b10}) begin
      errors++;
      $display("FAIL lock_accept: got addr %h rdy %b expected addr 2000 rdy 10",
               s_icb_cmd_addr, {m0_icb_cmd_ready, m1_icb_cmd_ready});
    end
    step();
    m0_icb_cmd_valid = 0;
    #1;
    checks++;
    if ({s_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready} !== {32'h3000, 2'b01}) begin
      errors++;
      $display("FAIL lock_next_m1: got addr %h rdy %b expected addr 3000 rdy 01",
               s_icb_cmd_addr, {m0_icb_cmd_ready, m1_icb_cmd_ready});
    end
    step();
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0; s_icb_rsp_valid = 1;
    repeat (3) step();
    s_icb_rsp_valid = 0;
  endtask

  task automatic test_full();
    apply_reset();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h40; s_icb_cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({m0_icb_cmd_ready, s_icb_cmd_valid} !== 2'b11) begin
        errors++;
        $display("FAIL full_fill_%0d: got %b expected 11", i, {m0_icb_cmd_ready, s_icb_cmd_valid});
      end
      step();
    end
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h77;
    #1;
    checks++;
    if ({m0_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready, m0_icb_rsp_valid} !== 4'b0011) begin
      errors++;
      $display("FAIL full_no_bypass: got %b expected 0011",
               {m0_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready, m0_icb_rsp_valid});
    end
    step();
    s_icb_rsp_valid = 0;
    #1;
    checks++;
    if ({m0_icb_cmd_ready, s_icb_cmd_valid} !== 2'b11) begin
      errors++;
      $display("FAIL full_after_pop: got %b expected 11", {m0_icb_cmd_ready, s_icb_cmd_valid});
    end
    step();
    m0_icb_cmd_valid = 0; s_icb_rsp_valid = 1;
    repeat (4) step();
    s_icb_rsp_valid = 0;
    #1;
    checks++;
    if (s_icb_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got s_rsp_ready=%b expected 0", s_icb_rsp_ready);
    end
  endtask

  task automatic test_routing();
    logic [31:0] wd [3];
    logic        who [3];
    wd = '{32'h11, 32'h22, 32'h33};
    who = '{1'b1, 1'b0, 1'b1};
    apply_reset();
    s_icb_cmd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      m0_icb_cmd_valid = !who[i]; m0_icb_cmd_wdata = wd[i];
      m1_icb_cmd_valid = who[i];  m1_icb_cmd_wdata = wd[i];
      #1;
      checks++;
      if ({s_icb_cmd_wdata, m1_icb_cmd_ready, m0_icb_cmd_ready} !== {wd[i], who[i], !who[i]}) begin
        errors++;
        $display("FAIL route_cmd_%0d: got wdata %h rdy %b", i, s_icb_cmd_wdata,
                 {m1_icb_cmd_ready, m0_icb_cmd_ready});
      end
      step();
    end
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hA1;
    #1;
    checks++;
    if ({m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_rdata} !== {2'b10, 32'hA1}) begin
      errors++;
      $display("FAIL route_rsp0: got %b rdata %h expected 10 rdata a1",
               {m1_icb_rsp_valid, m0_icb_rsp_valid}, m1_icb_rsp_rdata);
    end
    step();
    s_icb_rsp_rdata = 32'hA2; m0_icb_rsp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b010) begin
        errors++;
        $display("FAIL route_stall_%0d: got %b expected 010", i,
                 {s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
      end
      step();
    end
    m0_icb_rsp_ready = 1;
    #1;
    checks++;
    if ({s_icb_rsp_ready, m0_icb_rsp_valid, m0_icb_rsp_rdata} !== {2'b11, 32'hA2}) begin
      errors++;
      $display("FAIL route_rsp1: got %b rdata %h expected 11 rdata a2",
               {s_icb_rsp_ready, m0_icb_rsp_valid}, m0_icb_rsp_rdata);
    end
    step();
    s_icb_rsp_rdata = 32'hA3;
    #1;
    checks++;
    if ({m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready} !== 3'b101) begin
      errors++;
      $display("FAIL route_rsp2: got %b expected 101",
               {m1_icb_rsp_valid, m0_icb_rsp_valid, s_icb_rsp_ready});
    end
    step();
    #1;
    checks++;
    if ({s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL route_spurious: got %b expected 000",
               {s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
    end
    s_icb_rsp_valid = 0;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    s_icb_cmd_ready = 1; m0_icb_cmd_valid = 1;
    step();
    step();
    s_icb_cmd_ready = 0; m1_icb_cmd_valid = 1;
    step();
    rst = 1; s_icb_cmd_ready = 1; s_icb_rsp_valid = 1;
    #1;
    checks++;
    if ({m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready,
         m0_icb_rsp_valid, m1_icb_rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got %b expected 000000", {m0_icb_cmd_ready,
               m1_icb_cmd_ready, s_icb_cmd_valid, s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
    end
    step();
    rst = 0;
    #1;
    checks++;
    if ({m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}
        !== 5'b10000) begin
      errors++;
      $display("FAIL midop_first_grant: got %b expected 10000", {m0_icb_cmd_ready,
               m1_icb_cmd_ready, s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
    end
    s_icb_rsp_valid = 0;
    step();
    #1;
    checks++;
    if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midop_second_grant: got %b expected 01", {m0_icb_cmd_ready, m1_icb_cmd_ready});
    end
    step();
    idle();
    s_icb_rsp_valid = 1;
    repeat (2) step();
    s_icb_rsp_valid = 0;
    #1;
    checks++;
    if (s_icb_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_drain: got s_rsp_ready=%b expected 0", s_icb_rsp_ready);
    end
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_fairness();
    test_lock();
    test_full();
    test_routing();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
